// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between instruction fetch and the data port.
// Data has priority, but the streak limit stops fetch from being starved.
module mem_port_arbiter #(
  parameter int NB_WORD       = 32,
  parameter int NB_ADDR       = 32,
  parameter int MAX_DM_STREAK = 4,
  parameter int TIMEOUT       = 16
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  input  logic                 i_if_req,
  input  logic [NB_ADDR-1:0]   i_if_addr,
  output logic [NB_WORD-1:0]   o_if_rdata,
  output logic                 o_if_valid,
  output logic                 o_if_stall,
  input  logic                 i_dm_req,
  input  logic                 i_dm_we,
  input  logic [NB_WORD/8-1:0] i_dm_be,
  input  logic [NB_ADDR-1:0]   i_dm_addr,
  input  logic [NB_WORD-1:0]   i_dm_wdata,
  output logic [NB_WORD-1:0]   o_dm_rdata,
  output logic                 o_dm_valid,
  output logic                 o_dm_stall,
  output logic                 o_bus_err,
  output logic                 o_mem_req,
  output logic                 o_mem_we,
  output logic [NB_WORD/8-1:0] o_mem_be,
  output logic [NB_ADDR-1:0]   o_mem_addr,
  output logic [NB_WORD-1:0]   o_mem_wdata,
  input  logic                 i_mem_ack,
  input  logic [NB_WORD-1:0]   i_mem_rdata
);

  localparam int SK_W = $clog2(MAX_DM_STREAK + 1);
  localparam int TO_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, IF_BUSY, DM_BUSY, RESP} state_t;

  state_t          state, state_nxt;
  logic [SK_W-1:0] streak;
  logic [TO_W-1:0] to_cnt;
  logic            grant_dm, grant_if, busy, ack_done, to_done, fin;

  always_comb begin
    state_nxt = state;
    grant_dm  = 1'b0;
    grant_if  = 1'b0;
    busy      = (state == IF_BUSY) || (state == DM_BUSY);
    ack_done  = busy && i_mem_ack;
    to_done   = busy && !i_mem_ack && (TIMEOUT != 0) &&
                (to_cnt == TO_W'(TIMEOUT - 1));
    fin       = ack_done || to_done;
    case (state)
      IDLE: begin
        grant_dm = i_dm_req && (!i_if_req || (streak < SK_W'(MAX_DM_STREAK)));
        grant_if = !grant_dm && i_if_req;
        if (grant_dm)      state_nxt = DM_BUSY;
        else if (grant_if) state_nxt = IF_BUSY;
      end
      IF_BUSY, DM_BUSY: if (fin) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Stalls are purely combinational so the pipeline freezes in the request cycle.
  assign o_if_stall = i_if_req && !o_if_valid;
  assign o_dm_stall = i_dm_req && !o_dm_valid;

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state       <= IDLE;
      streak      <= '0;
      to_cnt      <= '0;
      o_mem_req   <= 1'b0;
      o_mem_we    <= 1'b0;
      o_mem_be    <= '0;
      o_mem_addr  <= '0;
      o_mem_wdata <= '0;
      o_if_valid  <= 1'b0;
      o_dm_valid  <= 1'b0;
      o_bus_err   <= 1'b0;
      o_if_rdata  <= '0;
      o_dm_rdata  <= '0;
    end else begin
      state      <= state_nxt;
      o_if_valid <= fin && (state == IF_BUSY);
      o_dm_valid <= fin && (state == DM_BUSY);
      o_bus_err  <= to_done;

      if (state == IDLE) begin
        if (grant_if || !i_if_req)
          streak <= '0;
        else if (grant_dm && (streak != SK_W'(MAX_DM_STREAK)))
          streak <= streak + 1'b1;
      end

      if (busy && !i_mem_ack && (TIMEOUT != 0))
        to_cnt <= to_cnt + 1'b1;
      else
        to_cnt <= '0;

      if (grant_dm) begin
        o_mem_req   <= 1'b1;
        o_mem_we    <= i_dm_we;
        o_mem_be    <= i_dm_be;
        o_mem_addr  <= i_dm_addr;
        o_mem_wdata <= i_dm_wdata;
      end else if (grant_if) begin
        o_mem_req   <= 1'b1;
        o_mem_we    <= 1'b0;
        o_mem_be    <= '0;
        o_mem_addr  <= i_if_addr;
        o_mem_wdata <= '0;
      end else if (fin) begin
        o_mem_req   <= 1'b0;
      end

      // A write completion leaves the data-port read register untouched.
      if (state == IF_BUSY) begin
        if (ack_done)     o_if_rdata <= i_mem_rdata;
        else if (to_done) o_if_rdata <= '0;
      end
      if (state == DM_BUSY) begin
        if (ack_done && !o_mem_we) o_dm_rdata <= i_mem_rdata;
        else if (to_done)          o_dm_rdata <= '0;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: inputs change and outputs are sampled on negedge.
module tb_mem_port_arbiter;

  logic        i_clock = 1'b0;
  logic        i_reset;
  logic        i_if_req;
  logic [31:0] i_if_addr;
  logic [31:0] o_if_rdata;
  logic        o_if_valid, o_if_stall;
  logic        i_dm_req, i_dm_we;
  logic [3:0]  i_dm_be;
  logic [31:0] i_dm_addr, i_dm_wdata, o_dm_rdata;
  logic        o_dm_valid, o_dm_stall, o_bus_err;
  logic        o_mem_req, o_mem_we;
  logic [3:0]  o_mem_be;
  logic [31:0] o_mem_addr, o_mem_wdata;
  logic        i_mem_ack;
  logic [31:0] i_mem_rdata;

  int checks = 0;
  int errors = 0;

  always #5 i_clock = ~i_clock;

  mem_port_arbiter #(
    .NB_WORD(32), .NB_ADDR(32), .MAX_DM_STREAK(4), .TIMEOUT(8)
  ) dut (
    .i_clock(i_clock), .i_reset(i_reset),
    .i_if_req(i_if_req), .i_if_addr(i_if_addr), .o_if_rdata(o_if_rdata),
    .o_if_valid(o_if_valid), .o_if_stall(o_if_stall),
    .i_dm_req(i_dm_req), .i_dm_we(i_dm_we), .i_dm_be(i_dm_be),
    .i_dm_addr(i_dm_addr), .i_dm_wdata(i_dm_wdata), .o_dm_rdata(o_dm_rdata),
    .o_dm_valid(o_dm_valid), .o_dm_stall(o_dm_stall), .o_bus_err(o_bus_err),
    .o_mem_req(o_mem_req), .o_mem_we(o_mem_we), .o_mem_be(o_mem_be),
    .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata),
    .i_mem_ack(i_mem_ack), .i_mem_rdata(i_mem_rdata)
  );

  task automatic test_reset();
    logic [5:0] flags;
    i_reset = 1'b0; i_if_req = 0; i_if_addr = 0; i_dm_req = 0; i_dm_we = 0;
    i_dm_be = 0; i_dm_addr = 0; i_dm_wdata = 0; i_mem_ack = 0; i_mem_rdata = 0;
    @(negedge i_clock); @(negedge i_clock);
    flags = {o_mem_req, o_if_valid, o_dm_valid, o_bus_err, o_if_stall, o_dm_stall};
    checks++;
    if (flags !== 6'b0) begin
      errors++; $display("FAIL reset_flags got %b exp %b", flags, 6'b0);
    end
    checks++;
    if ({o_if_rdata, o_dm_rdata, o_mem_addr, o_mem_wdata, o_mem_be, o_mem_we} !== 134'b0) begin
      errors++; $display("FAIL reset_data got %h %h %h %h exp all zero",
                         o_if_rdata, o_dm_rdata, o_mem_addr, o_mem_wdata);
    end
    i_if_req = 1; #1;
    checks++;
    if (o_if_stall !== 1'b1 || o_mem_req !== 1'b0) begin
      errors++; $display("FAIL reset_stall got stall=%b req=%b exp stall=1 req=0", o_if_stall, o_mem_req);
    end
    i_if_req = 0;
    @(negedge i_clock);
    i_reset = 1'b1;
    @(negedge i_clock);
  endtask

  task automatic test_if_read();
    @(negedge i_clock);
    i_if_req = 1; i_if_addr = 32'h10; #1;
    checks++;
    if (o_if_stall !== 1'b1 || o_mem_req !== 1'b0) begin
      errors++; $display("FAIL if_c0 got stall=%b req=%b exp stall=1 req=0", o_if_stall, o_mem_req);
    end
    @(negedge i_clock);
    checks++;
    if ({o_mem_req, o_mem_we, o_mem_be, o_mem_addr, o_if_stall} !== {1'b1, 1'b0, 4'h0, 32'h10, 1'b1}) begin
      errors++; $display("FAIL if_c1 got req=%b we=%b be=%h addr=%h stall=%b exp 1 0 0 00000010 1",
                         o_mem_req, o_mem_we, o_mem_be, o_mem_addr, o_if_stall);
    end
    i_mem_ack = 1; i_mem_rdata = 32'h13;
    @(negedge i_clock);
    i_mem_ack = 0; i_mem_rdata = 0;
    checks++;
    if (o_if_valid !== 1'b1 || o_if_rdata !== 32'h13) begin
      errors++; $display("FAIL if_c2_valid got valid=%b rdata=%h exp 1 00000013", o_if_valid, o_if_rdata);
    end
    checks++;
    if ({o_if_stall, o_mem_req, o_dm_valid, o_bus_err} !== 4'b0) begin
      errors++; $display("FAIL if_c2_ctrl got stall=%b req=%b dmv=%b err=%b exp 0 0 0 0",
                         o_if_stall, o_mem_req, o_dm_valid, o_bus_err);
    end
    i_if_req = 0;
    @(negedge i_clock);
    checks++;
    if (o_if_valid !== 1'b0 || o_mem_req !== 1'b0) begin
      errors++; $display("FAIL if_c3 got valid=%b req=%b exp 0 0", o_if_valid, o_mem_req);
    end
  endtask

  task automatic test_priority();
    @(negedge i_clock);
    i_if_req = 1; i_if_addr = 32'h80;
    i_dm_req = 1; i_dm_we = 0; i_dm_addr = 32'h200;
    @(negedge i_clock);
    checks++;
    if ({o_mem_req, o_mem_we, o_mem_addr, o_if_stall, o_dm_stall} !== {1'b1, 1'b0, 32'h200, 1'b1, 1'b1}) begin
      errors++; $display("FAIL prio_c1 got req=%b we=%b addr=%h ifst=%b dmst=%b exp 1 0 00000200 1 1",
                         o_mem_req, o_mem_we, o_mem_addr, o_if_stall, o_dm_stall);
    end
    i_mem_ack = 1; i_mem_rdata = 32'hCAFE0001;
    @(negedge i_clock);
    i_mem_ack = 0;
    checks++;
    if ({o_dm_valid, o_if_valid} !== 2'b10 || o_dm_rdata !== 32'hCAFE0001) begin
      errors++; $display("FAIL prio_c2 got dmv=%b ifv=%b rdata=%h exp 1 0 cafe0001",
                         o_dm_valid, o_if_valid, o_dm_rdata);
    end
    i_dm_req = 0;
    @(negedge i_clock);
    checks++;
    if (o_mem_req !== 1'b0 || o_if_stall !== 1'b1) begin
      errors++; $display("FAIL prio_c3 got req=%b ifst=%b exp 0 1", o_mem_req, o_if_stall);
    end
    @(negedge i_clock);
    checks++;
    if (o_mem_req !== 1'b1 || o_mem_addr !== 32'h80) begin
      errors++; $display("FAIL prio_c4 got req=%b addr=%h exp 1 00000080", o_mem_req, o_mem_addr);
    end
    i_mem_ack = 1; i_mem_rdata = 32'h93;
    @(negedge i_clock);
    i_mem_ack = 0; i_mem_rdata = 0;
    checks++;
    if ({o_if_valid, o_dm_valid} !== 2'b10 || o_if_rdata !== 32'h93) begin
      errors++; $display("FAIL prio_c5 got ifv=%b dmv=%b rdata=%h exp 1 0 00000093",
                         o_if_valid, o_dm_valid, o_if_rdata);
    end
    i_if_req = 0;
    @(negedge i_clock);
  endtask

  task automatic test_write_wait();
    @(negedge i_clock);
    i_dm_req = 1; i_dm_we = 1; i_dm_be = 4'b0011; i_dm_addr = 32'h100; i_dm_wdata = 32'hDEADBEEF;
    for (int c = 1; c <= 4; c++) begin
      @(negedge i_clock);
      checks++;
      if ({o_mem_req, o_mem_we, o_mem_be, o_mem_addr, o_mem_wdata, o_dm_valid} !==
          {1'b1, 1'b1, 4'b0011, 32'h100, 32'hDEADBEEF, 1'b0}) begin
        errors++; $display("FAIL wr_busy%0d got req=%b we=%b be=%b addr=%h wdata=%h dmv=%b exp 1 1 0011 00000100 deadbeef 0",
                           c, o_mem_req, o_mem_we, o_mem_be, o_mem_addr, o_mem_wdata, o_dm_valid);
      end
      if (c == 4) begin i_mem_ack = 1; i_mem_rdata = 32'h12345678; end
    end
    @(negedge i_clock);
    i_mem_ack = 0; i_mem_rdata = 0;
    checks++;
    if ({o_dm_valid, o_mem_req, o_bus_err} !== 3'b100 || o_dm_rdata !== 32'hCAFE0001) begin
      errors++; $display("FAIL wr_done got dmv=%b req=%b err=%b rdata=%h exp 1 0 0 cafe0001",
                         o_dm_valid, o_mem_req, o_bus_err, o_dm_rdata);
    end
    i_dm_req = 0; i_dm_we = 0; i_dm_be = 0;
    @(negedge i_clock);
    checks++;
    if (o_dm_valid !== 1'b0) begin
      errors++; $display("FAIL wr_after got dmv=%b exp 0", o_dm_valid);
    end
  endtask

  task automatic test_timeout();
    @(negedge i_clock);
    i_if_req = 1; i_if_addr = 32'h20;
    for (int c = 1; c <= 8; c++) begin
      @(negedge i_clock);
      checks++;
      if (o_mem_req !== 1'b1 || o_if_valid !== 1'b0) begin
        errors++; $display("FAIL to_busy%0d got req=%b ifv=%b exp 1 0", c, o_mem_req, o_if_valid);
      end
    end
    @(negedge i_clock);
    checks++;
    if ({o_if_valid, o_bus_err, o_mem_req} !== 3'b110 || o_if_rdata !== 32'h0) begin
      errors++; $display("FAIL to_resp got ifv=%b err=%b req=%b rdata=%h exp 1 1 0 00000000",
                         o_if_valid, o_bus_err, o_mem_req, o_if_rdata);
    end
    i_if_req = 0;
    @(negedge i_clock);
    checks++;
    if ({o_if_valid, o_bus_err, o_mem_req, o_if_stall} !== 4'b0) begin
      errors++; $display("FAIL to_idle got ifv=%b err=%b req=%b st=%b exp 0 0 0 0",
                         o_if_valid, o_bus_err, o_mem_req, o_if_stall);
    end
  endtask

  task automatic test_back_to_back();
    int dm_cnt = 0, if_cnt = 0, run = 0, both = 0;
    int runs[2] = '{0, 0};
    @(negedge i_clock);
    i_if_req = 1; i_if_addr = 32'h40;
    i_dm_req = 1; i_dm_we = 0; i_dm_addr = 32'h300;
    for (int c = 1; c <= 30; c++) begin
      @(negedge i_clock);
      if (o_dm_valid && o_if_valid) both++;
      if (o_dm_valid) begin dm_cnt++; run++; end
      if (o_if_valid) begin
        if (if_cnt < 2) runs[if_cnt] = run;
        run = 0; if_cnt++;
      end
      i_mem_ack = o_mem_req; i_mem_rdata = 32'h0BADF00D;
    end
    i_if_req = 0; i_dm_req = 0; i_mem_ack = 0; i_mem_rdata = 0;
    checks++;
    if (dm_cnt !== 8 || if_cnt !== 2 || both !== 0) begin
      errors++; $display("FAIL b2b_counts got dm=%0d if=%0d both=%0d exp 8 2 0", dm_cnt, if_cnt, both);
    end
    checks++;
    if (runs[0] !== 4 || runs[1] !== 4) begin
      errors++; $display("FAIL b2b_streak got runs %0d %0d exp 4 4", runs[0], runs[1]);
    end
    checks++;
    if (o_if_rdata !== 32'h0BADF00D) begin
      errors++; $display("FAIL b2b_ifdata got %h exp 0badf00d", o_if_rdata);
    end
    @(negedge i_clock);
    checks++;
    if (o_mem_req !== 1'b0) begin
      errors++; $display("FAIL b2b_idle got req=%b exp 0", o_mem_req);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge i_clock);
    i_dm_req = 1; i_dm_we = 0; i_dm_addr = 32'h240;
    @(negedge i_clock);
    checks++;
    if (o_mem_req !== 1'b1 || o_mem_addr !== 32'h240) begin
      errors++; $display("FAIL rst_busy got req=%b addr=%h exp 1 00000240", o_mem_req, o_mem_addr);
    end
    #2 i_reset = 1'b0;
    #1;
    checks++;
    if (o_mem_req !== 1'b0 || o_dm_valid !== 1'b0) begin
      errors++; $display("FAIL rst_async got req=%b dmv=%b exp 0 0", o_mem_req, o_dm_valid);
    end
    @(negedge i_clock);
    checks++;
    if ({o_dm_valid, o_mem_req, o_dm_stall} !== 3'b001 || o_dm_rdata !== 32'h0) begin
      errors++; $display("FAIL rst_held got dmv=%b req=%b st=%b rdata=%h exp 0 0 1 00000000",
                         o_dm_valid, o_mem_req, o_dm_stall, o_dm_rdata);
    end
    i_reset = 1'b1;
    @(negedge i_clock);
    checks++;
    if (o_mem_req !== 1'b1 || o_mem_addr !== 32'h240 || o_dm_valid !== 1'b0) begin
      errors++; $display("FAIL rst_reissue got req=%b addr=%h dmv=%b exp 1 00000240 0",
                         o_mem_req, o_mem_addr, o_dm_valid);
    end
    i_mem_ack = 1; i_mem_rdata = 32'h5555AAAA;
    @(negedge i_clock);
    i_mem_ack = 0; i_mem_rdata = 0;
    checks++;
    if ({o_dm_valid, o_bus_err} !== 2'b10 || o_dm_rdata !== 32'h5555AAAA) begin
      errors++; $display("FAIL rst_done got dmv=%b err=%b rdata=%h exp 1 0 5555aaaa",
                         o_dm_valid, o_bus_err, o_dm_rdata);
    end
    i_dm_req = 0;
    @(negedge i_clock);
  endtask

  initial begin
    test_reset();
    test_if_read();
    test_priority();
    test_write_wait();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
